// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// valid/ready handshake on operand and result sides.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   dvd_raw;
  logic [WIDTH-1:0]   dvs_mag;
  logic [WIDTH-1:0]   dq;
  logic [WIDTH-1:0]   pr;
  logic               q_neg;
  logic               r_neg;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    logic signed [WIDTH-1:0] sx;
    sx = x;
    return (sgn && sx < 0) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  // Trial is two bits wider than the divisor so an unsigned divisor with its
  // MSB set still yields a trustworthy borrow bit.
  assign shifted = {pr, dq[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_mag};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            dvd_raw  <= dividend;
            dvs_mag  <= mag(divisor, is_signed);
            dq       <= mag(dividend, is_signed);
            pr       <= '0;
            q_neg    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg    <= is_signed && dividend[WIDTH-1];
            cnt      <= CNT_W'(WIDTH);
            state    <= (divisor == '0) ? DONE : CALC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CALC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (!trial[WIDTH+1]) begin
              pr <= trial[WIDTH-1:0];
              dq <= {dq[WIDTH-2:0], 1'b1};
            end else begin
              pr <= shifted[WIDTH-1:0];
              dq <= {dq[WIDTH-2:0], 1'b0};
            end
          end else begin
            quotient    <= neg_if(dq, q_neg);
            remainder   <= neg_if(pr, r_neg);
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Entered with out_valid low only on the divide-by-zero path.
          if (!out_valid) begin
            quotient    <= '1;
            remainder   <= dvd_raw;
            div_by_zero <= 1'b1;
            out_valid   <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reference vectors, latency, backpressure,
// divide by zero, overflow and mid-operation reset.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; returns edges counted since the caller's accept edge.
  task automatic wait_out(input string tag, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100 && !got; k++) begin
      tick();
      if (out_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk({tag, "_out_valid_seen"}, 32'(got), 32'd1);
  endtask

  // Full transaction: called #1 after a rising edge.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic sgn, input logic [31:0] exp_q, input logic [31:0] exp_r,
                     input logic exp_dbz, input int exp_lat);
    int lat;
    for (int k = 0; k < 50 && !in_ready; k++) tick();
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    tick();
    in_valid = 1'b0;
    chk({tag, "_in_ready_fall"}, 32'(in_ready), 32'd0);
    wait_out(tag, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_quotient"}, quotient, exp_q);
    chk({tag, "_remainder"}, remainder, exp_r);
    chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(exp_dbz));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    resetn = 1'b1;
    tick();
    chk("rst_release_ready", 32'(in_ready), 32'd1);

    run("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33);
    run("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33);
    run("u_fff9_2", 32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0, 33);
    run("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 33);
    run("s_7_m7",   32'd7,          32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFFF,  32'd0,          1'b0, 33);
    run("u_5_0",    32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1, 1);
    run("s_5_0",    32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1, 1);
    run("s_m20_0",  32'hFFFF_FFEC,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFEC,  1'b1, 1);
    run("u_big",    32'hFFFF_FFFF,  32'h8000_0001,  1'b0, 32'd1,          32'h7FFF_FFFE,  1'b0, 33);
    run("s_m100_7", 32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33);

    // Backpressure with a second request held pending.
    in_valid  = 1'b1;
    dividend  = 32'd50;
    divisor   = 32'd6;
    is_signed = 1'b0;
    tick();
    dividend = 32'd9;
    divisor  = 32'd4;
    wait_out("bp1", lat);
    chk("bp1_latency", 32'(lat), 32'd33);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_quotient", quotient, 32'd8);
      chk("bp_hold_remainder", remainder, 32'd2);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_hs_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp2_accepted", 32'(in_ready), 32'd0);
    wait_out("bp2", lat);
    chk("bp2_latency", 32'(lat), 32'd33);
    chk("bp2_quotient", quotient, 32'd2);
    chk("bp2_remainder", remainder, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset at edge 10 of a calculation.
    in_valid  = 1'b1;
    dividend  = 32'd100;
    divisor   = 32'd7;
    is_signed = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    resetn = 1'b0;
    tick();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    resetn = 1'b1;
    tick();
    chk("abort_ready_back", 32'(in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle 32-bit integer divider producing quotient and remainder, signed or unsigned, through a valid/ready handshake on both sides. It is the iterative counterpart to the combinational adder/subtractor datapath. It reuses a single WIDTH+1-bit subtract per cycle (restoring division) instead of a full-width array. It sits beside the adder/subtractor in the integer execute path and handles the divide/remainder class of operations.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 2.
- clk  input  1  sole clock; all state updates on rising edge.
- resetn  input  1  synchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  divider idle and able to accept.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- is_signed  input  1  1 = two's-complement operands/results; 0 = unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  divisor was zero for this result; valid with out_valid.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch operands and is_signed;
  - compute magnitudes (|x| when is_signed and MSB set, else raw);
  - record quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend), both forced 0 when unsigned;
  - clear the partial remainder and load the iteration counter with WIDTH.
  - Divisor == 0 goes to DONE instead of CALC.
- CALC, one quotient bit per cycle:
  - shift {partial remainder, dividend magnitude} left 1;
  - trial = partial remainder − divisor magnitude (WIDTH+1 bits);
  - if trial ≥ 0, keep trial and set quotient bit 1; else restore and set bit 0.
  - Decrement the counter. After the WIDTH-th iteration, apply the sign fixups (negate quotient/remainder per the recorded signs) and go to DONE.
- DONE: out_valid=1. Outputs hold stable until out_valid&&out_ready, then go to IDLE.
- Divide by zero: quotient = all ones, remainder = original dividend (unmodified, both modes), div_by_zero=1.
- Signed overflow (most-negative / −1): quotient = most-negative value (0x80000000), remainder = 0, div_by_zero=0. This falls out of the magnitude arithmetic with no special case.
- Remainder sign always matches the dividend (truncating division). Zero results are never negative.
- No overlap: a new request is accepted only in IDLE.

## Timing
- Reset (resetn low at an edge): state=IDLE; in_ready, out_valid, div_by_zero, quotient, remainder all 0. in_ready is registered and rises on the first edge with resetn high.
- Reset mid-operation (CALC or DONE) aborts. The in-flight result is discarded and never presented; outputs return to reset values at that edge.
- Latency, accepting edge = edge 0:
  - normal: out_valid rises at edge WIDTH+1 (33 for WIDTH=32);
  - divide by zero: out_valid rises at edge 1.
- in_ready falls at edge 0 and stays low until the edge after the output handshake.
- Minimum request-to-request spacing: WIDTH+3 cycles normal, 3 for divide by zero.
- out_valid, once high, stays high with quotient/remainder/div_by_zero unchanged until the out_ready handshake.
- in_valid while in_ready=0 is ignored; the requester must hold it.

## Test plan
- Unsigned 100 / 7 → quotient 14, remainder 2, div_by_zero 0; out_valid exactly 33 cycles after accept.
- Signed −7 / 2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Unsigned 0xFFFFFFF9 / 2 → quotient 0x7FFFFFFC, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, div_by_zero 0. Signed 7 / −7 → quotient 0xFFFFFFFF, remainder 0.
- 5 / 0 (both modes) → quotient 0xFFFFFFFF, remainder 5, div_by_zero 1; out_valid 1 cycle after accept.
- Backpressure: hold out_ready low 10 cycles after out_valid → outputs unchanged, in_ready 0 throughout. A second request pending with in_valid=1 is accepted only the cycle after out_ready=1, with correct results for both.
- Drive resetn low at edge 10 of a CALC → no out_valid ever appears for that request. in_ready returns 1 one edge after release, and a fresh 9 / 3 then yields quotient 3, remainder 0.
